// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: command/response handshake bundle for spi_master_ctrl.
//   cmd_*  : one SPI transaction request (valid/ready), slave index, length, tx bits
//   rsp_*  : received bits or rejection flag (valid/ready)
// master modport is the requester (CPU-side wrapper), slave modport is the controller.
// Optional macro SPI_MASTER_CTRL_LSB_EN adds cmd_lsb (LSB-first transfer request).
interface spi_master_ctrl_if #(
  parameter int NSS    = 8,
  parameter int DATA_W = 16
);
  localparam int SW = (NSS > 1) ? $clog2(NSS) : 1;
  localparam int LW = $clog2(DATA_W + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [SW-1:0]     cmd_ss;
  logic [LW-1:0]     cmd_len;
  logic [DATA_W-1:0] cmd_data;
`ifdef SPI_MASTER_CTRL_LSB_EN
  logic              cmd_lsb;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_ss, cmd_len, cmd_data,
`ifdef SPI_MASTER_CTRL_LSB_EN
    output cmd_lsb,
`endif
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_ss, cmd_len, cmd_data,
`ifdef SPI_MASTER_CTRL_LSB_EN
    input  cmd_lsb,
`endif
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master, one full transaction per command
// (select, clock, shift, deselect). All outputs are registered.
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   bus            : spi_master_ctrl_if.slave (cmd_* in, rsp_* out)
//   busy           : controller not idle
//   spi_sck/ss/mosi: SPI pins (sck idles 0, ss active-low, mosi idles 1)
//   spi_miso       : SPI data from slave
// Optional macro SPI_MASTER_CTRL_LSB_EN: honours bus.cmd_lsb for LSB-first transfers.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// SETUP | ss asserted, first mosi bit presented, sck low for DIV cycles
// HIGH  | sck high for DIV cycles, miso sampled on the last one
// LOW   | sck low for DIV cycles, shift on the first one
// RESP  | pins idle, response held until rsp_ready
module spi_master_ctrl #(
  parameter int DIV    = 4,
  parameter int NSS    = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  spi_master_ctrl_if.slave  bus,
  output logic              busy,
  output logic              spi_sck,
  output logic [NSS-1:0]    spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso
);
  localparam int SW = (NSS > 1) ? $clog2(NSS) : 1;
  localparam int LW = $clog2(DATA_W + 1);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(DATA_W);
  localparam logic [SW:0]   SS_LIMIT = (SW + 1)'(NSS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] HIGH  = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sr;
  logic [LW-1:0]     bitcnt;
  logic [LW-1:0]     len_q;
  logic              lsb_q;
  logic              sample;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              lsb_in;
  logic              cmd_bad;
  logic [DATA_W-1:0] len_mask;
  logic [DATA_W-1:0] sr_load;
  logic              first_low;
  logic [DATA_W-1:0] sr_shift;
  logic [DATA_W-1:0] sr_final;
  logic [LW-1:0]     bitcnt_left;
  logic [DATA_W-1:0] rsp_value;

  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] v);
    for (int i = 0; i < DATA_W; i++) rev[i] = v[DATA_W-1-i];
  endfunction

`ifdef SPI_MASTER_CTRL_LSB_EN
  assign lsb_in = bus.cmd_lsb;
`else
  assign lsb_in = 1'b0;
`endif

  assign cmd_bad  = (bus.cmd_len == '0) || (bus.cmd_len > LEN_MAX) ||
                    ({1'b0, bus.cmd_ss} >= SS_LIMIT);
  // Bits above len are masked so they can never surface in rsp_data.
  assign len_mask = ~({DATA_W{1'b1}} << bus.cmd_len);
  assign sr_load  = lsb_in ? rev(bus.cmd_data & len_mask)
                           : (bus.cmd_data << (LEN_MAX - bus.cmd_len));

  // With DIV=1 the first and last LOW cycle coincide, so the shift result is
  // forwarded into the end-of-LOW decision and the response.
  assign first_low   = (cnt == CNT_LAST);
  assign sr_shift    = {sr[DATA_W-2:0], sample};
  assign sr_final    = first_low ? sr_shift : sr;
  assign bitcnt_left = first_low ? (bitcnt - LW'(1)) : bitcnt;
  assign rsp_value   = lsb_q ? (rev(sr_final) >> (LEN_MAX - len_q)) : sr_final;

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      bitcnt      <= '0;
      len_q       <= '0;
      lsb_q       <= 1'b0;
      sample      <= 1'b0;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      spi_sck     <= 1'b0;
      spi_ss      <= '1;
      spi_mosi    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            sr      <= sr_load;
            bitcnt  <= bus.cmd_len;
            len_q   <= bus.cmd_len;
            lsb_q   <= lsb_in;
            cnt     <= CNT_LAST;
            ready_q <= 1'b0;
            busy    <= 1'b1;
            if (cmd_bad) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state    <= SETUP;
              spi_ss   <= ~(NSS'(1) << bus.cmd_ss);
              spi_mosi <= sr_load[DATA_W-1];
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state   <= HIGH;
            spi_sck <= 1'b1;
            cnt     <= CNT_LAST;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            sample  <= spi_miso;
            state   <= LOW;
            spi_sck <= 1'b0;
            cnt     <= CNT_LAST;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        LOW: begin
          if (first_low) begin
            sr       <= sr_shift;
            spi_mosi <= sr_shift[DATA_W-1];
            bitcnt   <= bitcnt - LW'(1);
          end
          if (cnt == '0) begin
            cnt <= CNT_LAST;
            if (bitcnt_left != '0) begin
              state   <= HIGH;
              spi_sck <= 1'b1;
            end else begin
              state       <= RESP;
              spi_ss      <= '1;
              spi_mosi    <= 1'b1;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= rsp_value;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            busy        <= 1'b0;
            cnt         <= CNT_LAST;
          end
        end
        default: begin
          state       <= IDLE;
          ready_q     <= 1'b1;
          busy        <= 1'b0;
          rsp_valid_q <= 1'b0;
          spi_sck     <= 1'b0;
          spi_ss      <= '1;
          spi_mosi    <= 1'b1;
        end
      endcase
    end
  end
endmodule
